// File: rtl/axon_step_scheduler_if.sv
// Downstream bus of the axon step scheduler: weight-memory read port plus the
// valid/ready delivery channel into the soma accumulator.
interface axon_step_scheduler_if #(
  parameter int AXON_CNT_BIT_WIDTH = 1,
  parameter int WEIGHT_WIDTH       = 16
);
  logic                          weight_rd_en;
  logic [AXON_CNT_BIT_WIDTH-1:0] weight_addr;
  logic [WEIGHT_WIDTH-1:0]       weight_rd_data;
  logic                          acc_valid;
  logic                          acc_ready;
  logic [WEIGHT_WIDTH-1:0]       acc_weight;
  logic [AXON_CNT_BIT_WIDTH-1:0] acc_axon_id;

  modport master (
    output weight_rd_en,
    output weight_addr,
    input  weight_rd_data,
    output acc_valid,
    input  acc_ready,
    output acc_weight,
    output acc_axon_id
  );

  modport slave (
    input  weight_rd_en,
    input  weight_addr,
    output weight_rd_data,
    input  acc_valid,
    output acc_ready,
    input  acc_weight,
    input  acc_axon_id
  );
endinterface

// File: rtl/axon_step_scheduler.sv
// Sequences one synaptic-integration time step: snapshots the spike vector,
// fetches the weight of every spiking axon in ascending order and hands it on.
module axon_step_scheduler #(
  parameter int  AXON_CNT_BIT_WIDTH = 1,
  parameter int  WEIGHT_WIDTH       = 16,
  parameter int  MEM_LATENCY        = 1,
  parameter int  STEP_CNT_WIDTH     = 16,
  localparam int NUM_AXONS          = 1 << AXON_CNT_BIT_WIDTH
) (
  input  logic                      neuron_clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [NUM_AXONS-1:0]      spike,
  axon_step_scheduler_if.master     bus,
  output logic                      busy,
  output logic                      step_done,
  output logic [STEP_CNT_WIDTH-1:0] step_count,
  output logic                      overrun
);

  // Wide enough to hold the largest legal MEM_LATENCY of 4.
  localparam int LAT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_READ,
    S_WAIT,
    S_ACC,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [NUM_AXONS-1:0]          pending;
  logic [AXON_CNT_BIT_WIDTH-1:0] axon_ptr;
  logic [LAT_W-1:0]              lat_cnt;
  logic [WEIGHT_WIDTH-1:0]       acc_weight_q;
  logic [AXON_CNT_BIT_WIDTH-1:0] acc_axon_id_q;
  logic [STEP_CNT_WIDTH-1:0]     step_count_q;
  logic                          overrun_q;

  logic last_axon;
  logic snap;
  logic ptr_inc;
  logic load_lat;
  logic capture;
  logic accept;
  logic count_step;

  assign last_axon = (axon_ptr == '1);

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    snap       = 1'b0;
    ptr_inc    = 1'b0;
    load_lat   = 1'b0;
    capture    = 1'b0;
    accept     = 1'b0;
    count_step = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          snap       = 1'b1;
          state_next = S_SCAN;
        end
      end
      S_SCAN: begin
        if (pending[axon_ptr]) begin
          state_next = S_READ;
        end else if (last_axon) begin
          state_next = S_DONE;
        end else begin
          ptr_inc = 1'b1;
        end
      end
      S_READ: begin
        load_lat   = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        // The edge that takes the counter from 1 to 0 is the capture edge.
        if (lat_cnt == LAT_W'(1)) begin
          capture    = 1'b1;
          state_next = S_ACC;
        end
      end
      S_ACC: begin
        if (bus.acc_ready) begin
          accept = 1'b1;
          if (last_axon) begin
            state_next = S_DONE;
          end else begin
            ptr_inc    = 1'b1;
            state_next = S_SCAN;
          end
        end
      end
      S_DONE: begin
        count_step = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge neuron_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge neuron_clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      axon_ptr <= '0;
    end else begin
      if (snap) begin
        pending  <= spike;
        axon_ptr <= '0;
      end else begin
        if (accept) begin
          pending[axon_ptr] <= 1'b0;
        end
        if (ptr_inc) begin
          axon_ptr <= axon_ptr + AXON_CNT_BIT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge neuron_clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt <= '0;
    end else if (load_lat) begin
      lat_cnt <= LAT_W'(MEM_LATENCY);
    end else if (state == S_WAIT) begin
      lat_cnt <= lat_cnt - LAT_W'(1);
    end
  end

  // The delivered weight and id stay frozen while the accumulator stalls.
  always_ff @(posedge neuron_clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_weight_q  <= '0;
      acc_axon_id_q <= '0;
    end else if (capture) begin
      acc_weight_q  <= bus.weight_rd_data;
      acc_axon_id_q <= axon_ptr;
    end
  end

  always_ff @(posedge neuron_clk or negedge rst_n) begin
    if (!rst_n) begin
      step_count_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      if (count_step) begin
        step_count_q <= step_count_q + STEP_CNT_WIDTH'(1);
      end
      // A start that finds the scheduler busy is dropped but remembered.
      if (start && (state != S_IDLE)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign bus.weight_rd_en = (state == S_READ);
  assign bus.weight_addr  = axon_ptr;
  assign bus.acc_valid    = (state == S_ACC);
  assign bus.acc_weight   = acc_weight_q;
  assign bus.acc_axon_id  = acc_axon_id_q;

  assign busy       = (state != S_IDLE);
  assign step_done  = (state == S_DONE);
  assign step_count = step_count_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_axon_step_scheduler.sv
// Bench for axon_step_scheduler: directed and random steps against a
// transaction-level expectation built from the spike vector and stall choices.
module tb_axon_step_scheduler;

  localparam int AW = 2;
  localparam int NA = 1 << AW;
  localparam int WW = 16;
  localparam int ML = 3;
  localparam int SW = 2;

  logic          neuron_clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [NA-1:0] spike;
  logic          busy;
  logic          step_done;
  logic [SW-1:0] step_count;
  logic          overrun;

  axon_step_scheduler_if #(.AXON_CNT_BIT_WIDTH(AW), .WEIGHT_WIDTH(WW)) bus ();

  axon_step_scheduler #(
    .AXON_CNT_BIT_WIDTH(AW),
    .WEIGHT_WIDTH      (WW),
    .MEM_LATENCY       (ML),
    .STEP_CNT_WIDTH    (SW)
  ) dut (
    .neuron_clk(neuron_clk),
    .rst_n     (rst_n),
    .start     (start),
    .spike     (spike),
    .bus       (bus),
    .busy      (busy),
    .step_done (step_done),
    .step_count(step_count),
    .overrun   (overrun)
  );

  always #5 neuron_clk = ~neuron_clk;

  // Weight memory: a read enters a pipeline of ML stages; data is only valid
  // while it sits in the final stage, otherwise the bus shows a poison value.
  logic [WW-1:0] mem [NA];
  logic [ML-1:0] pipe_v = '0;
  logic [AW-1:0] pipe_a [ML];

  always @(posedge neuron_clk) begin
    pipe_v[0] <= bus.weight_rd_en;
    pipe_a[0] <= bus.weight_addr;
    for (int i = 1; i < ML; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_a[i] <= pipe_a[i-1];
    end
  end

  assign bus.weight_rd_data = pipe_v[ML-1] ? mem[pipe_a[ML-1]] : 16'hDEAD;

  // Observation log and accumulator responder.
  int            busy_cycles = 0;
  int            done_cnt    = 0;
  int            done_at     = 0;
  int            valid_total = 0;
  int            unstable    = 0;
  int            multi_rd    = 0;
  int            vcyc        = 0;
  bit            outstanding = 1'b0;
  logic [WW-1:0] held_w;
  logic [AW-1:0] held_id;
  int            rd_q [$];
  int            dlv_id_q [$];
  int            dlv_w_q [$];
  int            stall_tab [NA];

  initial begin
    bus.acc_ready = 1'b0;
    forever begin
      @(posedge neuron_clk);
      #2;
      if (!rst_n) begin
        outstanding   = 1'b0;
        vcyc          = 0;
        bus.acc_ready = 1'b0;
      end else begin
        if (busy) busy_cycles++;
        if (step_done) begin
          done_cnt++;
          done_at = busy_cycles;
        end
        if (bus.weight_rd_en) begin
          if (outstanding) multi_rd++;
          outstanding = 1'b1;
          rd_q.push_back(int'(bus.weight_addr));
        end
        if (bus.acc_valid) begin
          if (vcyc == 0) begin
            held_w  = bus.acc_weight;
            held_id = bus.acc_axon_id;
          end else if (bus.acc_weight !== held_w || bus.acc_axon_id !== held_id) begin
            unstable++;
          end
          vcyc++;
          valid_total++;
          bus.acc_ready = (vcyc > stall_tab[held_id]);
          if (bus.acc_ready) begin
            dlv_id_q.push_back(int'(held_id));
            dlv_w_q.push_back(int'(held_w));
            vcyc        = 0;
            outstanding = 1'b0;
          end
        end else begin
          vcyc          = 0;
          bus.acc_ready = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  int checks   = 0;
  int failures = 0;
  int cnt_exp  = 0;
  bit ov_exp   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},       32'(busy),            32'd0);
    check({tag, "_step_done"},  32'(step_done),       32'd0);
    check({tag, "_step_count"}, 32'(step_count),      32'd0);
    check({tag, "_overrun"},    32'(overrun),         32'd0);
    check({tag, "_rd_en"},      32'(bus.weight_rd_en), 32'd0);
    check({tag, "_addr"},       32'(bus.weight_addr), 32'd0);
    check({tag, "_acc_valid"},  32'(bus.acc_valid),   32'd0);
    check({tag, "_acc_weight"}, 32'(bus.acc_weight),  32'd0);
    check({tag, "_acc_id"},     32'(bus.acc_axon_id), 32'd0);
  endtask

  // One full step; stall_fix < 0 picks a random stall (0..3) per axon.
  task automatic run_step(input logic [NA-1:0] vec, input bit chg, input bit extra,
                          input int stall_fix);
    int rd_base, dlv_base, busy_base, done_base, vt_base, uns_base, mr_base;
    int exp_busy, exp_valid, n, k;
    @(negedge neuron_clk);
    rd_base   = rd_q.size();
    dlv_base  = dlv_id_q.size();
    busy_base = busy_cycles;
    done_base = done_cnt;
    vt_base   = valid_total;
    uns_base  = unstable;
    mr_base   = multi_rd;
    // NUM_AXONS scan cycles + DONE, plus READ + ML waits + (stall+1) per spike.
    exp_busy  = NA + 1;
    exp_valid = 0;
    for (int i = 0; i < NA; i++) begin
      stall_tab[i] = (stall_fix >= 0) ? stall_fix : int'($urandom_range(0, 3));
      if (vec[i]) begin
        exp_busy  += 2 + ML + stall_tab[i];
        exp_valid += stall_tab[i] + 1;
      end
    end
    spike = vec;
    start = 1'b1;
    @(negedge neuron_clk);
    start = 1'b0;
    if (chg) spike = ~vec;
    if (extra) begin
      @(negedge neuron_clk);
      start = 1'b1;
      @(negedge neuron_clk);
      start  = 1'b0;
      ov_exp = 1'b1;
    end
    n = 0;
    while (done_cnt == done_base && n < 500) begin
      @(negedge neuron_clk);
      n++;
    end
    check("step_timeout", 32'(n < 500), 32'd1);
    repeat (4) @(negedge neuron_clk);
    cnt_exp = (cnt_exp + 1) % (1 << SW);
    check("idle_after_step", 32'(busy),                  32'd0);
    check("done_pulses",     32'(done_cnt - done_base),  32'd1);
    check("done_latency",    32'(done_at - busy_base),   32'(exp_busy));
    check("busy_cycles",     32'(busy_cycles - busy_base), 32'(exp_busy));
    check("valid_cycles",    32'(valid_total - vt_base), 32'(exp_valid));
    check("acc_stable",      32'(unstable - uns_base),   32'd0);
    check("one_outstanding", 32'(multi_rd - mr_base),    32'd0);
    check("step_count",      32'(step_count),            32'(cnt_exp));
    check("overrun",         32'(overrun),               32'(ov_exp));
    check("read_count",      32'(rd_q.size() - rd_base),      32'($countones(vec)));
    check("deliver_count",   32'(dlv_id_q.size() - dlv_base), 32'($countones(vec)));
    k = 0;
    for (int i = 0; i < NA; i++) begin
      if (vec[i]) begin
        check("read_addr",   (rd_base + k < rd_q.size()) ? 32'(rd_q[rd_base + k]) : 32'hFFFF_FFFF,
              32'(i));
        check("deliver_id",  (dlv_base + k < dlv_id_q.size()) ? 32'(dlv_id_q[dlv_base + k])
                                                               : 32'hFFFF_FFFF, 32'(i));
        check("deliver_w",   (dlv_base + k < dlv_w_q.size()) ? 32'(dlv_w_q[dlv_base + k])
                                                              : 32'hFFFF_FFFF, 32'(mem[i]));
        k++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_base, done_base, dlv_base, n;
    for (int i = 0; i < NA; i++) begin
      mem[i] = {4'(i + 1), 12'($urandom)};
    end
    rst_n = 1'b0;
    start = 1'b0;
    spike = '0;
    repeat (3) @(negedge neuron_clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    run_step(4'b0000, 1'b0, 1'b0, 0);   // zero spikes
    run_step(4'b1111, 1'b0, 1'b0, 0);   // full vector, no stalls
    run_step(4'b0010, 1'b0, 1'b0, 5);   // sparse, long backpressure
    run_step(4'b1000, 1'b0, 1'b0, 1);   // only the last axon
    run_step(4'b0001, 1'b1, 1'b0, 0);   // spike vector changes after start
    run_step(4'b0101, 1'b1, 1'b1, 2);   // second start while busy

    // Abort a step from inside WAIT.
    @(negedge neuron_clk);
    for (int i = 0; i < NA; i++) stall_tab[i] = 0;
    rd_base   = rd_q.size();
    done_base = done_cnt;
    dlv_base  = dlv_id_q.size();
    spike = 4'b0100;
    start = 1'b1;
    @(negedge neuron_clk);
    start = 1'b0;
    n = 0;
    while (rd_q.size() == rd_base && n < 100) begin
      @(negedge neuron_clk);
      n++;
    end
    check("abort_read_seen", 32'(n < 100), 32'd1);
    @(negedge neuron_clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge neuron_clk);
    rst_n   = 1'b1;
    cnt_exp = 0;
    ov_exp  = 1'b0;
    repeat (8) @(negedge neuron_clk);
    check("abort_no_done",    32'(done_cnt - done_base),         32'd0);
    check("abort_no_deliver", 32'(dlv_id_q.size() - dlv_base),   32'd0);
    check("abort_idle",       32'(busy),                         32'd0);
    run_step(4'b0001, 1'b0, 1'b0, 0);

    // Step counter wraps through all-ones.
    repeat (5) run_step(4'b0000, 1'b0, 1'b0, 0);

    repeat (25) begin
      run_step(4'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
